// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between a CPU data port and a single-issue
// data memory. Stores are queued in a DEPTH-entry FIFO and drained in order.
// A load stalls the CPU until every earlier store has completed, then issues
// one downstream read.
//
// Optional feature macro: STORE_BUFFER_FWD_EN. When defined, a full-word load
// that hits a buffered full-word store returns the newest matching data after
// one stall cycle, without a downstream read.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_addr/_write_data/_sign_mask/_memwrite/_memread   CPU request (held while stalled)
//   cpu_read_data, cpu_stall   load result, registered stall
//   mem_addr/_write_data/_sign_mask/_memwrite/_memread   downstream request
//   mem_read_data, mem_clk_stall                         downstream result and busy flag
module store_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_write_data,
   input  logic [3:0]  cpu_sign_mask,
   input  logic        cpu_memwrite,
   input  logic        cpu_memread,
   output logic [31:0] cpu_read_data,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_sign_mask,
   output logic        mem_memwrite,
   output logic        mem_memread,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_WR = 2'd1,
      ISSUE_RD = 2'd2,
      BUSY     = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [31:0]   fifo_addr_q [DEPTH];
   logic [31:0]   fifo_data_q [DEPTH];
   logic [3:0]    fifo_mask_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          hold_v_q, hold_v_d;
   logic [31:0]   hold_addr_q, hold_addr_d, hold_data_q, hold_data_d;
   logic [3:0]    hold_mask_q, hold_mask_d;

   logic          ld_v_q, ld_v_d;
   logic [31:0]   ld_addr_q, ld_addr_d;
   logic [3:0]    ld_mask_q, ld_mask_d;

   logic          is_rd_q, is_rd_d;
   logic          cpu_stall_q, cpu_stall_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;

   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]    mem_mask_q, mem_mask_d;
   logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d;

   logic          pop, push, free, st_req, ld_req, rd_done;
   logic [31:0]   push_addr, push_data;
   logic [3:0]    push_mask;

`ifdef STORE_BUFFER_FWD_EN
   logic          fwd_v_q, fwd_v_d;
   logic [31:0]   fwd_data_q, fwd_data_d;
   logic          fwd_hit;
   logic [31:0]   fwd_word;
   logic [PW-1:0] fwd_idx;

   // Scan oldest to newest so the newest matching full-word store wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_word = '0;
      fwd_idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && fifo_mask_q[fwd_idx][2] &&
             (fifo_addr_q[fwd_idx][31:2] == cpu_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_word = fifo_data_q[fwd_idx];
         end
      end
   end
`endif

   // Request decode; a pop frees a slot in the same cycle it happens.
   assign pop     = (state_q == ISSUE_WR);
   assign free    = (count_q != CW'(DEPTH)) || pop;
   assign st_req  = !cpu_stall_q && cpu_memwrite;
   assign ld_req  = !cpu_stall_q && cpu_memread && !cpu_memwrite;
   assign rd_done = (state_q == BUSY) && is_rd_q && !mem_clk_stall;
   assign push    = free && (hold_v_q || st_req);

   assign push_addr = hold_v_q ? hold_addr_q : cpu_addr;
   assign push_data = hold_v_q ? hold_data_q : cpu_write_data;
   assign push_mask = hold_v_q ? hold_mask_q : cpu_sign_mask;

   // FIFO bookkeeping, holding register, pending load and CPU-side outputs.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      hold_v_d    = hold_v_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      hold_mask_d = hold_mask_q;
      ld_v_d      = ld_v_q;
      ld_addr_d   = ld_addr_q;
      ld_mask_d   = ld_mask_q;
      is_rd_d     = is_rd_q;
      cpu_stall_d = cpu_stall_q;
      cpu_rdata_d = cpu_rdata_q;
`ifdef STORE_BUFFER_FWD_EN
      fwd_v_d     = 1'b0;
      fwd_data_d  = fwd_data_q;
`endif
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      if (st_req && !free) begin
         hold_v_d    = 1'b1;
         hold_addr_d = cpu_addr;
         hold_data_d = cpu_write_data;
         hold_mask_d = cpu_sign_mask;
         cpu_stall_d = 1'b1;
      end
      if (hold_v_q && free) begin
         hold_v_d    = 1'b0;
         cpu_stall_d = 1'b0;
      end

      if (ld_req) begin
         cpu_stall_d = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
         if (cpu_sign_mask[2] && fwd_hit) begin
            fwd_v_d    = 1'b1;
            fwd_data_d = fwd_word;
         end else begin
            ld_v_d    = 1'b1;
            ld_addr_d = cpu_addr;
            ld_mask_d = cpu_sign_mask;
         end
`else
         ld_v_d    = 1'b1;
         ld_addr_d = cpu_addr;
         ld_mask_d = cpu_sign_mask;
`endif
      end

`ifdef STORE_BUFFER_FWD_EN
      if (fwd_v_q) begin
         cpu_rdata_d = fwd_data_q;
         cpu_stall_d = 1'b0;
      end
`endif

      if (state_q == ISSUE_WR) is_rd_d = 1'b0;
      if (state_q == ISSUE_RD) is_rd_d = 1'b1;

      if (rd_done) begin
         ld_v_d      = 1'b0;
         cpu_rdata_d = mem_read_data;
         cpu_stall_d = 1'b0;
      end
   end

   // Downstream FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Downstream FSM: next state; buffered stores go before a pending load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!mem_clk_stall) begin
               if (count_q != '0) state_d = ISSUE_WR;
               else if (ld_v_q)   state_d = ISSUE_RD;
            end
         end
         ISSUE_WR: state_d = BUSY;
         ISSUE_RD: state_d = BUSY;
         BUSY:     if (!mem_clk_stall) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Downstream FSM: outputs, registered so strobes are high only in ISSUE states.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_mask_d  = mem_mask_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      if ((state_q == IDLE) && (state_d == ISSUE_WR)) begin
         mem_addr_d  = fifo_addr_q[rd_ptr_q];
         mem_wdata_d = fifo_data_q[rd_ptr_q];
         mem_mask_d  = fifo_mask_q[rd_ptr_q];
         mem_we_d    = 1'b1;
      end else if ((state_q == IDLE) && (state_d == ISSUE_RD)) begin
         mem_addr_d = ld_addr_q;
         mem_mask_d = ld_mask_q;
         mem_re_d   = 1'b1;
      end
   end

   // FIFO storage needs no reset; validity is carried by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= push_addr;
         fifo_data_q[wr_ptr_q] <= push_data;
         fifo_mask_q[wr_ptr_q] <= push_mask;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         hold_v_q    <= 1'b0;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         hold_mask_q <= '0;
         ld_v_q      <= 1'b0;
         ld_addr_q   <= '0;
         ld_mask_q   <= '0;
         is_rd_q     <= 1'b0;
         cpu_stall_q <= 1'b0;
         cpu_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_mask_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
`ifdef STORE_BUFFER_FWD_EN
         fwd_v_q     <= 1'b0;
         fwd_data_q  <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         hold_v_q    <= hold_v_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         hold_mask_q <= hold_mask_d;
         ld_v_q      <= ld_v_d;
         ld_addr_q   <= ld_addr_d;
         ld_mask_q   <= ld_mask_d;
         is_rd_q     <= is_rd_d;
         cpu_stall_q <= cpu_stall_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_mask_q  <= mem_mask_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
`ifdef STORE_BUFFER_FWD_EN
         fwd_v_q     <= fwd_v_d;
         fwd_data_q  <= fwd_data_d;
`endif
      end
   end

   assign cpu_read_data  = cpu_rdata_q;
   assign cpu_stall      = cpu_stall_q;
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign mem_sign_mask  = mem_mask_q;
   assign mem_memwrite   = mem_we_q;
   assign mem_memread    = mem_re_q;

endmodule
